// File: rtl/param_data_memory.sv
// Single-port word memory with per-byte write enables and a READ_LATENCY-deep read pipeline.
// After reset the whole array is cleared one word per cycle before requests are accepted.
module param_data_memory #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 6,
    parameter int READ_LATENCY = 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    ReqValid,
    output logic                    ReqReady,
    input  logic                    ReqWrite,
    input  logic [ADDR_WIDTH-1:0]   ReqAddress,
    input  logic [DATA_WIDTH-1:0]   ReqWriteData,
    input  logic [DATA_WIDTH/8-1:0] ReqByteEnable,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    ReadValid,
    output logic                    InitDone
);

    // state | meaning
    // INIT  | clearing word[init_cnt] each cycle, requests ignored
    // RUN   | accepting one request per cycle
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 8;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_valid;

    logic wr_accept;
    logic rd_accept;

    assign ReqReady  = (state == ST_RUN);
    assign InitDone  = (state == ST_RUN);
    assign wr_accept = ReqValid && ReqReady && ReqWrite && !Reset;
    assign rd_accept = ReqValid && ReqReady && !ReqWrite && !Reset;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                state <= ST_RUN;
            end
        end
    end

    // Array has no reset of its own; the INIT sweep is what clears it.
    always_ff @(posedge Clock) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= '0;
        end else if (wr_accept) begin
            for (int b = 0; b < LANES; b++) begin
                if (ReqByteEnable[b]) begin
                    mem[ReqAddress][8*b +: 8] <= ReqWriteData[8*b +: 8];
                end
            end
        end
    end

    // Stage data only moves with a valid token, so the last stage holds between reads.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= rd_accept;
            if (rd_accept) begin
                pipe_data[0] <= mem[ReqAddress];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign ReadValid = pipe_valid[READ_LATENCY-1];
    assign ReadData  = pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_param_data_memory.sv
// Scoreboard bench: dut0 uses default parameters, dut1 uses READ_LATENCY=3.
// Expected reads are queued with data and arrival cycle; negedge monitors pop and compare.
module tb_param_data_memory;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    logic        rst0, v0, w0, rdy0, rv0, done0;
    logic [5:0]  a0;
    logic [31:0] wd0, rd0;
    logic [3:0]  be0;
    logic        rst1, v1, w1, rdy1, rv1, done1;
    logic [5:0]  a1;
    logic [31:0] wd1, rd1;
    logic [3:0]  be1;

    param_data_memory dut0 (
        .Clock(Clock), .Reset(rst0), .ReqValid(v0), .ReqReady(rdy0), .ReqWrite(w0),
        .ReqAddress(a0), .ReqWriteData(wd0), .ReqByteEnable(be0),
        .ReadData(rd0), .ReadValid(rv0), .InitDone(done0)
    );

    param_data_memory #(.READ_LATENCY(3)) dut1 (
        .Clock(Clock), .Reset(rst1), .ReqValid(v1), .ReqReady(rdy1), .ReqWrite(w1),
        .ReqAddress(a1), .ReqWriteData(wd1), .ReqByteEnable(be1),
        .ReadData(rd1), .ReadValid(rv1), .InitDone(done1)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] q0_data[$];
    int          q0_cyc[$];
    logic [31:0] q1_data[$];
    int          q1_cyc[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        logic [31:0] d;
        int c;
        if (rv0) begin
            if (q0_data.size() == 0) begin
                check("dut0_unexpected_readvalid", 32'(rv0), 32'd0);
            end else begin
                d = q0_data.pop_front();
                c = q0_cyc.pop_front();
                check("dut0_readdata", rd0, d);
                check("dut0_read_cycle", 32'(cyc), 32'(c));
            end
        end
        if (rv1) begin
            if (q1_data.size() == 0) begin
                check("dut1_unexpected_readvalid", 32'(rv1), 32'd0);
            end else begin
                d = q1_data.pop_front();
                c = q1_cyc.pop_front();
                check("dut1_readdata", rd1, d);
                check("dut1_read_cycle", 32'(cyc), 32'(c));
            end
        end
    end

    task automatic drive(int d, bit v, bit w, int a, logic [31:0] wd, logic [3:0] be);
        @(negedge Clock);
        if (d == 0) begin
            v0 = v; w0 = w; a0 = a[5:0]; wd0 = wd; be0 = be;
        end else begin
            v1 = v; w1 = w; a1 = a[5:0]; wd1 = wd; be1 = be;
        end
    endtask

    task automatic wr(int d, int a, logic [31:0] wd, logic [3:0] be);
        drive(d, 1'b1, 1'b1, a, wd, be);
    endtask

    task automatic rd(int d, int a, logic [31:0] exp);
        drive(d, 1'b1, 1'b0, a, 32'd0, 4'd0);
        if (d == 0) begin
            q0_data.push_back(exp);
            q0_cyc.push_back(cyc + 1);
        end else begin
            q1_data.push_back(exp);
            q1_cyc.push_back(cyc + 3);
        end
    endtask

    task automatic idle(int d);
        drive(d, 1'b0, 1'b0, 0, 32'd0, 4'd0);
    endtask

    // One-cycle reset, then count cycles until InitDone; optionally pokes requests during INIT.
    task automatic do_reset(int d, bit poke);
        int n;
        logic dn;
        @(negedge Clock);
        if (d == 0) begin rst0 = 1'b1; v0 = 1'b0; end
        else begin rst1 = 1'b1; v1 = 1'b0; end
        @(negedge Clock);
        if (d == 0) begin
            check("rst_readvalid", 32'(rv0), 32'd0);
            check("rst_readdata", rd0, 32'd0);
            check("rst_ready", 32'(rdy0), 32'd0);
            rst0 = 1'b0;
        end else begin
            check("rst_readvalid", 32'(rv1), 32'd0);
            check("rst_readdata", rd1, 32'd0);
            check("rst_ready", 32'(rdy1), 32'd0);
            rst1 = 1'b0;
        end
        n = 0;
        dn = (d == 0) ? done0 : done1;
        while (!dn && n < 200) begin
            n++;
            if (poke && d == 0) begin
                v0 = 1'b1; w0 = n[0]; a0 = 6'd0; wd0 = 32'hA5A5A5A5; be0 = 4'hF;
            end
            @(negedge Clock);
            dn = (d == 0) ? done0 : done1;
        end
        if (d == 0) v0 = 1'b0; else v1 = 1'b0;
        check("init_cycles", 32'(n), 32'd64);
        check("ready_after_init", 32'((d == 0) ? rdy0 : rdy1), 32'd1);
    endtask

    initial begin
        int t;
        rst0 = 1'b1; v0 = 1'b0; w0 = 1'b0; a0 = '0; wd0 = '0; be0 = '0;
        rst1 = 1'b1; v1 = 1'b0; w1 = 1'b0; a1 = '0; wd1 = '0; be1 = '0;
        repeat (2) @(negedge Clock);

        do_reset(0, 1'b0);
        for (int i = 0; i < 64; i++) rd(0, i, 32'h0);
        idle(0);

        wr(0, 5, 32'hDEADBEEF, 4'hF);
        rd(0, 5, 32'hDEADBEEF);
        idle(0);
        repeat (3) @(negedge Clock);
        check("hold_readvalid", 32'(rv0), 32'd0);
        check("hold_readdata", rd0, 32'hDEADBEEF);

        wr(0, 63, 32'hFFFFFFFF, 4'hF);
        wr(0, 63, 32'h12345678, 4'b0101);
        rd(0, 63, 32'hFF34FF78);
        wr(0, 63, 32'h00000000, 4'b0000);
        rd(0, 63, 32'hFF34FF78);
        rd(0, 0, 32'h0);
        wr(0, 10, 32'hCAFEF00D, 4'hF);
        wr(0, 11, 32'h01FFFFFF, 4'b1000);
        rd(0, 10, 32'hCAFEF00D);
        rd(0, 11, 32'h01000000);
        idle(0);
        repeat (3) @(negedge Clock);

        do_reset(0, 1'b1);
        rd(0, 0, 32'h0);
        rd(0, 5, 32'h0);
        rd(0, 63, 32'h0);
        idle(0);

        do_reset(1, 1'b0);
        wr(1, 1, 32'h11, 4'hF);
        wr(1, 2, 32'h22, 4'hF);
        wr(1, 3, 32'h33, 4'hF);
        rd(1, 1, 32'h11);
        rd(1, 2, 32'h22);
        rd(1, 3, 32'h33);
        idle(1);
        repeat (6) @(negedge Clock);

        wr(1, 7, 32'h77, 4'hF);
        drive(1, 1'b1, 1'b0, 1, 32'd0, 4'd0);
        drive(1, 1'b1, 1'b0, 2, 32'd0, 4'd0);
        do_reset(1, 1'b0);
        rd(1, 7, 32'h0);
        rd(1, 1, 32'h0);
        idle(1);

        t = 0;
        while ((q0_data.size() != 0 || q1_data.size() != 0) && t < 50) begin
            t++;
            @(negedge Clock);
        end
        repeat (3) @(negedge Clock);
        check("scoreboard_drained", 32'(q0_data.size() + q1_data.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 6: word address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter READ_LATENCY, default 1, legal range 1..4: cycles from request acceptance to read data.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: Clock input 1, the single clock, rising-edge only.
REQ-005 The block SHALL have port Reset, input, width 1: synchronous active-high reset.
REQ-006 The block SHALL have port ReqValid, input, width 1: request present.
REQ-007 The block SHALL have port ReqReady, output, width 1: block can accept a request this cycle.
REQ-008 The block SHALL have port ReqWrite, input, width 1: 1 = write, 0 = read.
REQ-009 The block SHALL have port ReqAddress, input, width ADDR_WIDTH: word address.
REQ-010 The block SHALL have port ReqWriteData, input, width DATA_WIDTH: write data.
REQ-011 The block SHALL have port ReqByteEnable, input, width DATA_WIDTH/8: per-byte write mask, bit i covering bits 8i+7:8i.
REQ-012 The block SHALL have port ReadData, output, width DATA_WIDTH: read result.
REQ-013 The block SHALL have port ReadValid, output, width 1: ReadData valid, one-cycle pulse per read.
REQ-014 The block SHALL have port InitDone, output, width 1: memory clear complete.

Function
REQ-015 The block SHALL implement a two-state FSM, INIT and RUN; Reset forces INIT with init counter = 0.
REQ-016 In INIT the block SHALL write 0 to word[counter] each cycle and increment the counter; after writing word DEPTH-1 it SHALL enter RUN (DEPTH cycles in INIT).
REQ-017 In INIT the block SHALL drive ReqReady=0 and InitDone=0 and ignore ReqValid; in RUN it SHALL drive ReqReady=1 and InitDone=1.
REQ-018 A request SHALL be accepted on a rising edge where ReqValid=1 and ReqReady=1; one request per cycle, fully pipelined, no back-pressure in RUN.
REQ-019 An accepted write SHALL update only the byte lanes whose ReqByteEnable bit is 1, at the acceptance edge; ByteEnable=0 SHALL leave the word unchanged.
REQ-020 An accepted write SHALL produce no ReadValid pulse.
REQ-021 An accepted read SHALL sample word[ReqAddress] at the acceptance edge k; ReadData/ReadValid SHALL be registered at edge k+READ_LATENCY-1, so READ_LATENCY=1 gives data in the cycle after acceptance.
REQ-022 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-023 Back-to-back reads SHALL produce back-to-back ReadValid pulses in request order, each READ_LATENCY cycles after its acceptance.
REQ-024 ReadData SHALL hold its last value while ReadValid=0.
REQ-025 ReqAddress SHALL always be in range (full ADDR_WIDTH decode); DEPTH-1 and 0 SHALL be addressed with no wrap side effects.
REQ-026 All state updates SHALL occur on the Clock rising edge; the block SHALL use no falling-edge logic.

Reset
REQ-027 While Reset=1 at a rising edge, the block SHALL set ReadValid=0, ReadData=0, InitDone=0, ReqReady=0, the FSM to INIT, and the counter to 0.
REQ-028 Reset mid-operation SHALL flush all in-flight reads, with no ReadValid after the reset edge, and restart the full DEPTH-cycle clear.
REQ-029 Reset asserted during INIT SHALL restart the counter at 0.

Verification
REQ-030 Defaults, with Reset held for 1 cycle then released SHALL give InitDone=0 and ReqReady=0 for exactly 64 cycles, then 1; a read of every address SHALL return 0x00000000.
REQ-031 Write addr 5 data 0xDEADBEEF BE=1111, then read addr 5 next cycle SHALL give ReadValid one cycle after read acceptance with ReadData=0xDEADBEEF.
REQ-032 Byte mask: write addr 63 0xFFFFFFFF BE=1111, then addr 63 0x12345678 BE=0101, then read SHALL return 0xFF34FF78; a write with BE=0000 SHALL leave 0xFF34FF78.
REQ-033 READ_LATENCY=3: reads to addr 1,2,3 on consecutive cycles holding 0x11,0x22,0x33 SHALL pulse ReadValid 3 cycles after each acceptance, consecutively, in order.
REQ-034 Reset mid-stream: with READ_LATENCY=3, assert Reset one cycle after issuing two reads SHALL give no ReadValid pulse, a fresh 64-cycle INIT, and previously written data reading back 0.
REQ-035 ReqValid=1 during INIT SHALL not modify memory and SHALL produce no ReadValid.
